fc_neuron: RTL and testbench

- Single fully-connected output neuron for the small CNN accelerator.
- Consumes pooled feature values from the pooling stage, two per beat (one per convolution kernel), over a 4-beat frame (8 pooled values total).
- Multiplies each pooled value by its signed weight, accumulates, applies ReLU, scales and saturates, and emits an 8-bit class score once per frame.

---
 rtl/fc_neuron.sv | 85 ++++++++
 tb/tb_fc_neuron.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fc_neuron.sv
// Single fully-connected output neuron: multiply-accumulate over a frame of pooled values, then ReLU, shift, saturate.
// Optional build macro FC_NEURON_BIAS_EN adds a signed bias port that seeds the accumulator on beat 0.
module fc_neuron #(
  parameter int N_KERNELS = 2,
  parameter int N_BEATS   = 4,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 20,
  parameter int SHIFT     = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  input  logic [N_KERNELS*DATA_W-1:0]           pooledPixelArray,
  input  logic [N_KERNELS*N_BEATS*DATA_W-1:0]   weight,
`ifdef FC_NEURON_BIAS_EN
  input  logic signed [15:0]                    bias,
`endif
  output logic [DATA_W-1:0]                     result,
  output logic                                  result_valid
);

  localparam int PROD_W = 2 * DATA_W + 1;
  localparam int BEAT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << DATA_W) - 1);

  logic [BEAT_W-1:0]        beat;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  sum_next;
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0]        y;
  logic signed [PROD_W-1:0] prod [N_KERNELS];

`ifdef FC_NEURON_BIAS_EN
  assign base = {{(ACC_W-16){bias[15]}}, bias};
`else
  assign base = '0;
`endif

  // Kernel 0 sits in the most significant pixel byte; weight byte index is beat*N_KERNELS + kernel.
  always_comb begin
    for (int k = 0; k < N_KERNELS; k++) begin
      prod[k] = $signed({1'b0, pooledPixelArray[(N_KERNELS-1-k)*DATA_W +: DATA_W]})
              * $signed(weight[(int'(beat) * N_KERNELS + k) * DATA_W +: DATA_W]);
    end
  end

  // NOTE: every variable written in always_comb gets its default first so no latch is inferred.
  always_comb begin
    sum_next = (beat == '0) ? base : acc;
    for (int k = 0; k < N_KERNELS; k++) begin
      sum_next = sum_next + {{(ACC_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]};
    end
    shifted = sum_next >>> SHIFT;
    if (sum_next[ACC_W-1])
      y = '0;
    else if (shifted > SAT_MAX)
      y = '1;
    else
      y = shifted[DATA_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat         <= '0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (in_valid) begin
        acc  <= sum_next;
        beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
        // Final sum goes straight to the output stage; no extra cycle after the last beat.
        if (beat == LAST_BEAT) begin
          result       <= y;
          result_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fc_neuron.sv
// Self-checking bench for fc_neuron: a frame-level arithmetic model checked every cycle, plus literal expectations.
module tb_fc_neuron;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] pix;
  logic [63:0] weight;
  logic [7:0]  result;
  logic        result_valid;
`ifdef FC_NEURON_BIAS_EN
  logic signed [15:0] bias;
`endif

  fc_neuron dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .pooledPixelArray (pix),
    .weight           (weight),
`ifdef FC_NEURON_BIAS_EN
    .bias             (bias),
`endif
    .result           (result),
    .result_valid     (result_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Frame-level model: running integer sum, result = clamp(sum/4, 0, 255) on the 4th valid beat.
  int m_beat = 0;
  int m_sum  = 0;
  int m_s    = 0;
  int exp_result = 0;
  int exp_valid  = 0;
  bit m_init = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_beat = 0; m_sum = 0; exp_result = 0; exp_valid = 0; m_init = 1'b1;
    end else begin
      exp_valid = 0;
      if (in_valid) begin
`ifdef FC_NEURON_BIAS_EN
        m_s = (m_beat == 0) ? int'(bias) : m_sum;
`else
        m_s = (m_beat == 0) ? 0 : m_sum;
`endif
        m_s += int'(pix[15:8]) * int'($signed(weight[(m_beat*2)*8 +: 8]));
        m_s += int'(pix[7:0])  * int'($signed(weight[(m_beat*2+1)*8 +: 8]));
        m_sum = m_s;
        if (m_beat == 3) begin
          exp_result = (m_s < 0) ? 0 : ((m_s / 4 > 255) ? 255 : m_s / 4);
          exp_valid  = 1;
        end
        m_beat = (m_beat + 1) % 4;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("cycle_valid",  int'(result_valid), exp_valid);
      check("cycle_result", int'(result), exp_result);
    end
  end

  task automatic beat(input logic [7:0] p0, input logic [7:0] p1);
    @(negedge clk);
    in_valid = 1'b1;
    pix      = {p0, p1};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] w, input logic [7:0] p);
    weight = {8{w}};
    repeat (4) beat(p, p);
    idle(1);
  endtask

  task automatic expect_pulse(input string name, input int val);
    check({name, "_model"}, exp_result, val);
    check({name, "_result"}, int'(result), val);
    check({name, "_valid"}, int'(result_valid), 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; pix = '0; weight = '0;
`ifdef FC_NEURON_BIAS_EN
    bias = '0;
`endif
    repeat (2) @(negedge clk);
    check("reset_result", int'(result), 0);
    check("reset_valid", int'(result_valid), 0);
    rst_n = 1'b1;
    idle(2);

    frame(8'h01, 8'd1);    expect_pulse("sum8", 2);
    idle(1);
    check("pulse_once", int'(result_valid), 0);
    frame(8'h04, 8'd16);   expect_pulse("sum512", 128);
    frame(8'h7F, 8'd255);  expect_pulse("saturate", 255);
    frame(8'hFF, 8'd10);   expect_pulse("relu", 0);

    // Gap of two idle cycles between beats 1 and 2.
    weight = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    beat(8'd1, 8'd1); beat(8'd1, 8'd1);
    idle(2);
    check("gap_valid", int'(result_valid), 0);
    check("gap_result_held", int'(result), 0);
    beat(8'd1, 8'd1); beat(8'd1, 8'd1);
    idle(1);
    expect_pulse("gap_sum36", 9);

    // Partial frame discarded by a one-cycle reset.
    weight = {8{8'h7F}};
    beat(8'd255, 8'd255); beat(8'd255, 8'd255);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_result", int'(result), 0);
    check("midreset_valid", int'(result_valid), 0);
    frame(8'h01, 8'd1);    expect_pulse("after_reset", 2);

    // Back-to-back frames: beat 0 of the next frame right after beat 3.
    weight = {8{8'h01}};
    repeat (4) beat(8'd255, 8'd255);
    weight = {8{8'h04}};
    beat(8'd16, 8'd16);
    expect_pulse("b2b_first", 255);
    repeat (3) beat(8'd16, 8'd16);
    idle(1);
    expect_pulse("b2b_second", 128);

`ifdef FC_NEURON_BIAS_EN
    bias = -16'sd4;
    frame(8'h01, 8'd1);    expect_pulse("bias_m4", 1);
    bias = -16'sd100;
    frame(8'h01, 8'd1);    expect_pulse("bias_m100", 0);
`endif

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
